jedro_1_lsu: RTL
================

Name: jedro_1_lsu

Overview:
- Load-store unit of the jedro_1 core; sits downstream of the decoder/ALU stage.
- Takes a decoded memory operation (lsu_ctrl_e encoding, ALU-computed address, store data, destination register) and runs one data-bus transaction: req/gnt address phase, then rvalid response phase.
- Returns aligned, sign/zero-extended load data for register write-back.
- Reports misaligned and access-fault exceptions to the CSR/trap logic using the mcause codes from jedro_1_defines.

Parameters:
- DATA_WIDTH, 32, data and address width (from jedro_1_defines).
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk_i  input  1  core clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- ctrl_valid_i  input  1  a memory operation is presented this cycle.
- ctrl_i  input  4  operation, lsu_ctrl_e encoding.
- addr_i  input  32  effective byte address.
- wdata_i  input  32  store data, right-aligned.
- regdest_i  input  5  load destination register.
- busy_o  output  1  an operation is in flight; decoder must stall.
- rf_wb_o  output  1  one-cycle write-back strobe.
- regdest_o  output  5  write-back register index.
- rdata_o  output  32  extended load result.
- exc_valid_o  output  1  one-cycle exception strobe.
- exc_cause_o  output  4  mcause code.
- exc_addr_o  output  32  faulting address, for mtval.
- data_req_o  output  1  bus request.
- data_gnt_i  input  1  bus grant.
- data_addr_o  output  32  word-aligned bus address.
- data_we_o  output  1  1 = store.
- data_be_o  output  4  byte enables.
- data_wdata_o  output  32  lane-positioned store data.
- data_rvalid_i  input  1  response valid.
- data_rdata_i  input  32  load data word.
- data_err_i  input  1  bus error, qualified by rvalid.

Behaviour:
- Reset (rstn_i low, asynchronous): state IDLE; all outputs 0.
- FSM has three states: IDLE, REQ, WAIT. busy_o = (state != IDLE).
- IDLE: ctrl_valid_i is sampled. Encodings 8..15 are ignored (no request, no exception).
- Misaligned detection in IDLE:
  - half-word with addr_i[0]=1, or word with addr_i[1:0]!=0.
  - No bus request is issued; state stays IDLE.
  - Next cycle: exc_valid_o=1, exc_addr_o=addr_i, exc_cause_o = 4 for loads, 6 for stores.
- Aligned operation: registers op, addr, regdest, be and wdata; moves to REQ. data_req_o is high starting the following cycle.
- REQ: data_req_o, data_addr_o, data_we_o, data_be_o and data_wdata_o are held stable until data_gnt_i=1. On grant, move to WAIT. data_req_o drops the cycle after the grant.
- WAIT: wait for data_rvalid_i; then return to IDLE. Outputs are registered and pulse in the following cycle:
  - load without error: rf_wb_o=1, regdest_o, rdata_o.
  - store without error: no strobe.
  - data_err_i=1: exc_valid_o=1 with cause 5 (load) or 7 (store), exc_addr_o = full byte address; rf_wb_o stays 0.
- Back-to-back: a new op may be accepted in the same cycle that a result or exception pulses (state is IDLE).
- Best-case load latency is 3 cycles: accept at c0, req+gnt at c1, rvalid at c2, rf_wb_o at c3.
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- data_addr_o = {addr[31:2], 2'b00}.
- Store data: byte replicated into all four lanes; half-word replicated into both halves; word passed through.
- Load extraction: byte lane selected by addr[1:0], half-word lane by addr[1].
  - LSU_LOAD_BYTE / LSU_LOAD_HALF_WORD sign-extend.
  - _U variants zero-extend.
  - word passes through.
- rvalid or gnt arriving in IDLE is ignored. gnt arriving while in WAIT is ignored.
- Reset mid-operation aborts the transaction with no write-back or exception. The bus slave shares rstn_i.
- rdata_o, regdest_o and exc_addr_o hold their last value when not strobed. exc_cause_o is 0 when idle.

Test Plan:
- LSU_LOAD_WORD addr 0x80000010, gnt after 2 cycles, rvalid 1 cycle later with 0x12345678 -> data_be_o=1111, data_addr_o=0x80000010, rf_wb_o pulse with rdata_o=0x12345678 and correct regdest_o; req held stable while waiting.
- LSU_LOAD_BYTE addr 0x80000003, rdata 0x80AABBCC -> rdata_o=0xFFFFFF80. LSU_LOAD_BYTE_U at the same address -> 0x00000080. LSU_LOAD_HALF_WORD_U addr 0x80000002 -> 0x000080AA.
- LSU_STORE_HALF_WORD addr 0x80000006, wdata_i 0x0000BEEF -> data_we_o=1, data_be_o=1100, data_wdata_o=0xBEEFBEEF, data_addr_o=0x80000004; no rf_wb_o.
- LSU_LOAD_WORD addr 0x80000001 -> no data_req_o; exc_valid_o pulse with cause 4 and exc_addr_o=0x80000001. LSU_STORE_HALF_WORD addr 0x80000003 -> cause 6.
- Load with data_err_i=1 on rvalid at addr 0x80000020 -> exc_valid_o with cause 5, exc_addr_o=0x80000020, rf_wb_o=0. Store with error -> cause 7.
- Assert rstn_i low while in REQ -> data_req_o=0 and busy_o=0 immediately. After release, a new LSU_LOAD_WORD completes normally with no stale write-back.

Source files
------------

// File: rtl/jedro_1_lsu_if.sv
// Data-bus interface of the jedro_1 load-store unit: req/gnt address phase,
// rvalid response phase. The LSU is the master.
interface jedro_1_lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    data_req_o;
  logic                    data_gnt_i;
  logic [DATA_WIDTH-1:0]   data_addr_o;
  logic                    data_we_o;
  logic [DATA_WIDTH/8-1:0] data_be_o;
  logic [DATA_WIDTH-1:0]   data_wdata_o;
  logic                    data_rvalid_i;
  logic [DATA_WIDTH-1:0]   data_rdata_i;
  logic                    data_err_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: one bus transaction per decoded memory op, with
// lane steering, load extension and misaligned/access-fault reporting.
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  input  logic [3:0]                ctrl_i,
  input  logic [DATA_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  output logic                      busy_o,
  output logic                      rf_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] regdest_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      exc_valid_o,
  output logic [3:0]                exc_cause_o,
  output logic [DATA_WIDTH-1:0]     exc_addr_o,
  jedro_1_lsu_if.master             bus
);
  // lsu_ctrl_e, low three bits; codes 8..15 are not memory ops
  localparam logic [2:0] LSU_LOAD_BYTE        = 3'd0;
  localparam logic [2:0] LSU_LOAD_HALF_WORD   = 3'd1;
  localparam logic [2:0] LSU_LOAD_WORD        = 3'd2;
  localparam logic [2:0] LSU_LOAD_BYTE_U      = 3'd3;
  localparam logic [2:0] LSU_LOAD_HALF_WORD_U = 3'd4;
  localparam logic [2:0] LSU_STORE_BYTE       = 3'd5;
  localparam logic [2:0] LSU_STORE_HALF_WORD  = 3'd6;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  state_e state, state_nxt;

  logic [1:0]                size_in;
  logic                      store_in, misal, accept, misal_exc, done;
  logic [3:0]                be_in;
  logic [DATA_WIDTH-1:0]     wdata_in;
  logic [2:0]                op_q;
  logic                      store_q;
  logic [DATA_WIDTH-1:0]     addr_q, wdata_q, load_data;
  logic [REG_ADDR_WIDTH-1:0] regdest_q;
  logic [3:0]                be_q;
  logic [7:0]                lb;
  logic [15:0]               lh;

  // size: 0 byte, 1 half-word, 2 word
  always_comb begin
    case (ctrl_i[2:0])
      LSU_LOAD_BYTE, LSU_LOAD_BYTE_U, LSU_STORE_BYTE:                size_in = 2'd0;
      LSU_LOAD_HALF_WORD, LSU_LOAD_HALF_WORD_U, LSU_STORE_HALF_WORD: size_in = 2'd1;
      default:                                                       size_in = 2'd2;
    endcase
    store_in = (ctrl_i[2:0] >= LSU_STORE_BYTE);
    misal    = (size_in == 2'd1 && addr_i[0]) || (size_in == 2'd2 && addr_i[1:0] != 2'b00);
    case (size_in)
      2'd0:    begin be_in = 4'b0001 << addr_i[1:0];             wdata_in = {4{wdata_i[7:0]}};  end
      2'd1:    begin be_in = addr_i[1] ? 4'b1100 : 4'b0011;      wdata_in = {2{wdata_i[15:0]}}; end
      default: begin be_in = 4'b1111;                            wdata_in = wdata_i;            end
    endcase
  end

  assign accept    = (state == S_IDLE) && ctrl_valid_i && !ctrl_i[3] && !misal;
  assign misal_exc = (state == S_IDLE) && ctrl_valid_i && !ctrl_i[3] && misal;
  assign done      = (state == S_WAIT) && bus.data_rvalid_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)            state_nxt = S_REQ;
      S_REQ:   if (bus.data_gnt_i)    state_nxt = S_WAIT;
      S_WAIT:  if (bus.data_rvalid_i) state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state != S_IDLE);
    bus.data_req_o = (state == S_REQ);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q <= '0; store_q <= 1'b0; addr_q <= '0; wdata_q <= '0; regdest_q <= '0; be_q <= '0;
    end else if (accept) begin
      op_q <= ctrl_i[2:0]; store_q <= store_in; addr_q <= addr_i;
      wdata_q <= wdata_in; regdest_q <= regdest_i; be_q <= be_in;
    end
  end

  assign bus.data_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign bus.data_we_o    = store_q;
  assign bus.data_be_o    = be_q;
  assign bus.data_wdata_o = wdata_q;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lb = bus.data_rdata_i[7:0];
      2'd1:    lb = bus.data_rdata_i[15:8];
      2'd2:    lb = bus.data_rdata_i[23:16];
      default: lb = bus.data_rdata_i[31:24];
    endcase
    lh = addr_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
    case (op_q)
      LSU_LOAD_BYTE:        load_data = {{(DATA_WIDTH-8){lb[7]}}, lb};
      LSU_LOAD_BYTE_U:      load_data = {{(DATA_WIDTH-8){1'b0}}, lb};
      LSU_LOAD_HALF_WORD:   load_data = {{(DATA_WIDTH-16){lh[15]}}, lh};
      LSU_LOAD_HALF_WORD_U: load_data = {{(DATA_WIDTH-16){1'b0}}, lh};
      default:              load_data = bus.data_rdata_i;
    endcase
  end

  // Strobes clear every cycle; data/index/address hold until the next strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rf_wb_o <= 1'b0; regdest_o <= '0; rdata_o <= '0;
      exc_valid_o <= 1'b0; exc_cause_o <= '0; exc_addr_o <= '0;
    end else begin
      rf_wb_o     <= 1'b0;
      exc_valid_o <= 1'b0;
      exc_cause_o <= '0;
      if (misal_exc) begin
        exc_valid_o <= 1'b1;
        exc_cause_o <= store_in ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
        exc_addr_o  <= addr_i;
      end else if (done) begin
        if (bus.data_err_i) begin
          exc_valid_o <= 1'b1;
          exc_cause_o <= store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
          exc_addr_o  <= addr_q;
        end else if (!store_q) begin
          rf_wb_o   <= 1'b1;
          regdest_o <= regdest_q;
          rdata_o   <= load_data;
        end
      end
    end
  end
endmodule
